// File: rtl/ped_request_ctrl.sv
// Pedestrian push-button front end: synchroniser, debouncer, request/WALK FSM
// with post-crossing cooldown and a saturating accepted-request counter.
module ped_request_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COOLDOWN_CYCLES = 32,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button_raw,
    input  logic             light_red,
    input  logic             ped_ack,
    output logic             ped_req,
    output logic             walk,
    output logic             wait_lamp,
    output logic [CNT_W-1:0] req_count
);

    localparam int DEB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int CD_W  = (COOLDOWN_CYCLES < 2) ? 1 : $clog2(COOLDOWN_CYCLES);

    typedef enum logic [1:0] {IDLE, PENDING, WALK, COOLDOWN} state_t;

    state_t           state;
    logic             sync1;
    logic             btn_s;
    logic             deb;
    logic             deb_q;
    logic             pend;
    logic [DEB_W-1:0] stab_cnt;
    logic [CD_W-1:0]  cd_cnt;
    logic             press;
    logic [CNT_W-1:0] count_inc;

    assign press     = deb & ~deb_q;
    assign count_inc = (&req_count) ? req_count : req_count + 1'b1;

    // Level changes are accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            btn_s    <= 1'b0;
            deb      <= 1'b0;
            deb_q    <= 1'b0;
            stab_cnt <= '0;
        end else begin
            sync1 <= button_raw;
            btn_s <= sync1;
            deb_q <= deb;
            if (btn_s != deb) begin
                if (stab_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb      <= btn_s;
                    stab_cnt <= '0;
                end else begin
                    stab_cnt <= stab_cnt + 1'b1;
                end
            end else begin
                stab_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ped_req   <= 1'b0;
            walk      <= 1'b0;
            wait_lamp <= 1'b0;
            pend      <= 1'b0;
            cd_cnt    <= '0;
            req_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        state     <= PENDING;
                        ped_req   <= 1'b1;
                        wait_lamp <= 1'b1;
                        req_count <= count_inc;
                    end
                end
                PENDING: begin
                    // An ack is only meaningful once the controller is actually showing red.
                    if (ped_ack && light_red) begin
                        state     <= WALK;
                        walk      <= 1'b1;
                        ped_req   <= 1'b0;
                        wait_lamp <= 1'b0;
                    end
                end
                WALK: begin
                    if (!light_red) begin
                        state  <= COOLDOWN;
                        walk   <= 1'b0;
                        cd_cnt <= CD_W'(COOLDOWN_CYCLES - 1);
                    end
                end
                COOLDOWN: begin
                    if (cd_cnt == '0) begin
                        // A press landing on the expiry cycle counts as a latched request.
                        if (pend || press) begin
                            state     <= PENDING;
                            pend      <= 1'b0;
                            ped_req   <= 1'b1;
                            wait_lamp <= 1'b1;
                            req_count <= count_inc;
                        end else begin
                            state     <= IDLE;
                            wait_lamp <= 1'b0;
                        end
                    end else begin
                        cd_cnt <= cd_cnt - 1'b1;
                        if (press) begin
                            pend      <= 1'b1;
                            wait_lamp <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    ped_req   <= 1'b0;
                    walk      <= 1'b0;
                    wait_lamp <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Bench for ped_request_ctrl: expected req_count values are queued per press and
// checked when ped_req rises; scenario tasks add inline timing checks.
module tb_ped_request_ctrl;

    logic       clk;
    logic       reset;
    logic       button_raw;
    logic       light_red;
    logic       ped_ack;
    logic       ped_req;
    logic       walk;
    logic       wait_lamp;
    logic [1:0] req_count;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    logic prev_req = 1'b0;

    ped_request_ctrl #(.DEBOUNCE_CYCLES(4), .COOLDOWN_CYCLES(32), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .button_raw(button_raw), .light_red(light_red),
        .ped_ack(ped_ack), .ped_req(ped_req), .walk(walk), .wait_lamp(wait_lamp),
        .req_count(req_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every rising ped_req must match a queued expected count.
    always @(negedge clk) begin
        if (ped_req === 1'b1 && prev_req !== 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_req: ped_req rose with nothing expected, req_count=%0d", req_count);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (req_count !== 2'(e)) begin
                    errors++;
                    $display("FAIL sb_req_count: actual=%0d required=%0d", req_count, e);
                end
            end
        end
        prev_req = ped_req;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; button_raw = 1'b0; ped_ack = 1'b0; light_red = 1'b0;
        tick(2);
        exp_q.delete();
        reset = 1'b0;
        tick(1);
    endtask

    task automatic press_btn(input int hold, input int low);
        button_raw = 1'b1;
        tick(hold);
        button_raw = 1'b0;
        tick(low);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (ped_req !== 1'b1 && n < 60) begin
            tick(1);
            n++;
        end
        checks++;
        if (ped_req !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: ped_req actual=%b required=1", name, ped_req);
        end
    endtask

    // Grant the crossing and end it; returns on the negedge just after COOLDOWN entry.
    task automatic grant_finish(input string name);
        light_red = 1'b1; ped_ack = 1'b1;
        tick(1);
        checks++;
        if ({walk, ped_req} !== 2'b10) begin
            errors++;
            $display("FAIL %s_walk_on: walk,ped_req actual=%b required=10", name, {walk, ped_req});
        end
        ped_ack = 1'b0; light_red = 1'b0;
        tick(1);
        checks++;
        if (walk !== 1'b0) begin
            errors++;
            $display("FAIL %s_walk_off: walk actual=%b required=0", name, walk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; button_raw = 1'b1; light_red = 1'b1; ped_ack = 1'b1;
        tick(2);
        checks++;
        if ({ped_req, walk, wait_lamp, req_count} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: actual=%b required=00000", {ped_req, walk, wait_lamp, req_count});
        end
        light_red = 1'b0; ped_ack = 1'b0;
        exp_q.push_back(1);
        reset = 1'b0;
        tick(6);
        checks++;
        if (ped_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_latency_early: ped_req actual=%b required=0 after 6 edges", ped_req);
        end
        tick(1);
        checks++;
        if (ped_req !== 1'b1 || req_count !== 2'd1) begin
            errors++;
            $display("FAIL reset_latency: ped_req=%b req_count=%0d required 1,1 after 7 edges", ped_req, req_count);
        end
        button_raw = 1'b0;
        tick(8);
    endtask

    task automatic test_glitch();
        do_reset();
        press_btn(3, 20);
        checks++;
        if (ped_req !== 1'b0 || req_count !== 2'd0) begin
            errors++;
            $display("FAIL glitch_filtered: ped_req=%b req_count=%0d required 0,0", ped_req, req_count);
        end
        exp_q.push_back(1);
        press_btn(6, 6);
        checks++;
        if (ped_req !== 1'b1 || req_count !== 2'd1) begin
            errors++;
            $display("FAIL glitch_long_press: ped_req=%b req_count=%0d required 1,1", ped_req, req_count);
        end
    endtask

    task automatic test_handshake();
        int bad = 0;
        ped_ack = 1'b1; light_red = 1'b0;
        tick(3);
        checks++;
        if ({ped_req, walk, wait_lamp} !== 3'b101) begin
            errors++;
            $display("FAIL hs_ack_no_red: req,walk,wait actual=%b required=101", {ped_req, walk, wait_lamp});
        end
        light_red = 1'b1;
        tick(1);
        checks++;
        if ({ped_req, walk, wait_lamp} !== 3'b010) begin
            errors++;
            $display("FAIL hs_walk: req,walk,wait actual=%b required=010", {ped_req, walk, wait_lamp});
        end
        ped_ack = 1'b0;
        tick(2);
        checks++;
        if (walk !== 1'b1) begin
            errors++;
            $display("FAIL hs_walk_hold: walk actual=%b required=1", walk);
        end
        light_red = 1'b0;
        tick(1);
        checks++;
        if (walk !== 1'b0) begin
            errors++;
            $display("FAIL hs_walk_end: walk actual=%b required=0", walk);
        end
        for (int k = 1; k <= 32; k++) begin
            tick(1);
            if ({ped_req, walk, wait_lamp} !== 3'b000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hs_cooldown_quiet: lamp-active cycles actual=%0d required=0", bad);
        end
        // Back in IDLE a fresh press must produce a request straight away.
        exp_q.push_back(2);
        press_btn(6, 6);
        checks++;
        if (ped_req !== 1'b1 || req_count !== 2'd2) begin
            errors++;
            $display("FAIL hs_idle_after_cd: ped_req=%b req_count=%0d required 1,2", ped_req, req_count);
        end
    endtask

    task automatic test_cooldown_latch();
        do_reset();
        exp_q.push_back(1);
        press_btn(6, 6);
        wait_req("latch_first");
        grant_finish("latch1");
        exp_q.push_back(2);
        button_raw = 1'b1;
        tick(5);
        button_raw = 1'b0;
        tick(2);
        checks++;
        if ({ped_req, wait_lamp} !== 2'b01) begin
            errors++;
            $display("FAIL latch_wait_lamp: req,wait actual=%b required=01", {ped_req, wait_lamp});
        end
        tick(24);
        checks++;
        if (ped_req !== 1'b0) begin
            errors++;
            $display("FAIL latch_early: ped_req actual=%b required=0 at cooldown cycle 31", ped_req);
        end
        tick(1);
        checks++;
        if (ped_req !== 1'b1 || req_count !== 2'd2) begin
            errors++;
            $display("FAIL latch_expiry: ped_req=%b req_count=%0d required 1,2", ped_req, req_count);
        end
        grant_finish("latch2");
        exp_q.push_back(3);
        repeat (3) press_btn(5, 5);
        checks++;
        if ({ped_req, wait_lamp} !== 2'b01) begin
            errors++;
            $display("FAIL latch_multi_wait: req,wait actual=%b required=01", {ped_req, wait_lamp});
        end
        tick(2);
        checks++;
        if (ped_req !== 1'b1 || req_count !== 2'd3) begin
            errors++;
            $display("FAIL latch_multi_count: ped_req=%b req_count=%0d required 1,3", ped_req, req_count);
        end
    endtask

    task automatic test_expiry_press();
        do_reset();
        exp_q.push_back(1);
        press_btn(6, 6);
        wait_req("expiry_first");
        grant_finish("expiry");
        tick(25);
        exp_q.push_back(2);
        button_raw = 1'b1;
        tick(6);
        checks++;
        if ({ped_req, wait_lamp} !== 2'b00) begin
            errors++;
            $display("FAIL expiry_before: req,wait actual=%b required=00", {ped_req, wait_lamp});
        end
        button_raw = 1'b0;
        tick(1);
        checks++;
        if (ped_req !== 1'b1 || req_count !== 2'd2) begin
            errors++;
            $display("FAIL expiry_same_cycle: ped_req=%b req_count=%0d required 1,2", ped_req, req_count);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            int e;
            e = (i > 3) ? 3 : i;
            exp_q.push_back(e);
            press_btn(6, 6);
            checks++;
            if (ped_req !== 1'b1 || req_count !== 2'(e)) begin
                errors++;
                $display("FAIL sat_round%0d: ped_req=%b req_count=%0d required 1,%0d", i, ped_req, req_count, e);
            end
            grant_finish("sat");
            tick(33);
        end
    endtask

    task automatic test_reset_mid_walk();
        do_reset();
        exp_q.push_back(1);
        press_btn(6, 6);
        light_red = 1'b1; ped_ack = 1'b1;
        tick(1);
        checks++;
        if (walk !== 1'b1) begin
            errors++;
            $display("FAIL midwalk_walk: walk actual=%b required=1", walk);
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if ({ped_req, walk, wait_lamp, req_count} !== 5'b0) begin
            errors++;
            $display("FAIL midwalk_reset: actual=%b required=00000", {ped_req, walk, wait_lamp, req_count});
        end
        reset = 1'b0;
        tick(20);
        checks++;
        if ({ped_req, walk} !== 2'b00) begin
            errors++;
            $display("FAIL midwalk_idle: req,walk actual=%b required=00", {ped_req, walk});
        end
        ped_ack = 1'b0; light_red = 1'b0;
        exp_q.push_back(1);
        press_btn(6, 6);
        checks++;
        if (ped_req !== 1'b1 || req_count !== 2'd1) begin
            errors++;
            $display("FAIL midwalk_new_press: ped_req=%b req_count=%0d required 1,1", ped_req, req_count);
        end
    endtask

    initial begin
        reset = 1'b1; button_raw = 1'b0; light_red = 1'b0; ped_ack = 1'b0;
        tick(1);
        test_reset();
        test_glitch();
        test_handshake();
        test_cooldown_latch();
        test_expiry_press();
        test_saturation();
        test_reset_mid_walk();
        tick(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: pending expected requests actual=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
